smm_block_accum: RTL
====================

// Module: smm_block_accum
// PURPOSE
//   Downstream of the 2x2 Strassen multiply core. Accumulates its 2x2 partial-product blocks
//   (one BUSWIDTH word per partial) into NUM_TILES output tiles of a larger block matrix
//   product, C_ij = sum over k of A_ik*B_kj. When every tile holds K_STEPS partials, it
//   streams the finished tiles out in tile order over a valid/ready port, then re-arms.
// PARAMETERS
//   DATAWIDTH  32  width of one signed matrix element
//   NUM_TILES  4   number of 2x2 output tiles per result (power of 2, >=2)
//   K_STEPS    2   partial products summed into each tile (>=1)
//   derived: BUSWIDTH = 4*DATAWIDTH; TW = $clog2(NUM_TILES); KW = $clog2(K_STEPS+1)
// PORTS
//   clk        in   1          clock, all logic on posedge
//   rst        in   1          reset: synchronous, active-high
//   in_valid   in   1          partial-product word valid
//   in_ready   out  1          partial accepted when in_valid && in_ready
//   in_data    in   BUSWIDTH   {C11,C10,C01,C00}, signed lanes, lane0 in LSBs
//   in_tile    in   TW         destination tile index of this partial
//   out_valid  out  1          finished tile presented
//   out_ready  in   1          consumer takes tile when out_valid && out_ready
//   out_data   out  BUSWIDTH   accumulated tile, same lane packing as in_data
//   out_tile   out  TW         index of the tile on out_data
//   out_last   out  1          high with the final tile (index NUM_TILES-1)
//   err        out  1          sticky: partial arrived for an already-complete tile
// BEHAVIOUR
//   State machine, two states: ACCUM (reset state) and DRAIN.
//   Reset: state=ACCUM, all accumulators=0, all per-tile counters=0, out_valid=0,
//     out_data=0, out_tile=0, out_last=0, err=0. Reset mid-drain or mid-accum discards
//     everything; in_ready=1 on the first cycle after reset.
//   in_ready = (state==ACCUM). out_valid = (state==DRAIN). Both are registered-state-based;
//     neither depends combinationally on in_valid/out_ready.
//   ACCUM, on an accepted partial to tile t with cnt[t] < K_STEPS:
//     - cnt[t]==0: acc[t] <= in_data (load, no add); else each lane acc[t].lane +=
//       in_data.lane, signed, modulo 2^DATAWIDTH (wrap, no saturation, no carry between lanes).
//     - cnt[t] <= cnt[t]+1. Result visible in acc one cycle after the handshake.
//   ACCUM, accepted partial to tile t with cnt[t]==K_STEPS: word dropped, acc/cnt unchanged,
//     err <= 1 (stays 1 until rst).
//   ACCUM -> DRAIN on the clock edge where the accepted partial makes every cnt == K_STEPS.
//     Latency: that handshake at edge n gives out_valid=1, out_tile=0 after edge n.
//     in_ready drops the same cycle out_valid rises.
//   DRAIN: drain pointer p starts at 0; out_data=acc[p], out_tile=p, out_last=(p==NUM_TILES-1).
//     Data held stable while out_valid && !out_ready. Each handshake advances p by 1.
//     Handshake with out_last: all acc and cnt cleared to 0, p=0, state -> ACCUM; in_ready=1
//     the next cycle. Partials are never accepted while in DRAIN (in_valid ignored).
//   Tiles may receive partials in any interleaving. Nothing drains until all tiles complete.
//   in_tile >= NUM_TILES (non-power-of-2 impossible by parameter rule): not applicable.
// TESTING
//   1 rst, then 8 partials (tile 0..3, k=0 then k=1), lanes {4,3,2,1}+{40,30,20,10} per tile
//     -> tiles 0..3 each out {44,33,22,11}; out_last only on tile 3; then in_ready=1.
//   2 Back-pressure: hold out_ready=0 for 5 cycles in DRAIN -> out_data/out_tile stable,
//     out_valid=1; release -> one tile per cycle, tile order 0,1,2,3.
//   3 Signed wrap: lane 0x7FFFFFFF + 0x00000001 -> 0x80000000; -5 + 3 -> -2 (0xFFFFFFFE);
//     adjacent lanes unaffected.
//   4 Interleaved/out-of-order: tile order 3,0,3,1,2,0,2,1 -> DRAIN exactly 1 cycle after
//     the 8th handshake, correct per-tile sums.
//   5 Overflow: third partial to tile 2 while tile 2 is complete -> err=1 one cycle later,
//     acc[2] unchanged, later results correct; err persists across the next drain.
//   6 rst asserted after tile 1 handshake in DRAIN -> next cycle out_valid=0, in_ready=1,
//     err=0; fresh run of test 1 produces correct output.

Source files
------------

// File: rtl/smm_block_accum.sv
// ============================================================================
// smm_block_accum: sums 2x2 partial-product blocks into NUM_TILES output tiles,
// then streams the finished tiles out in tile order before re-arming.
// Revision: 1.0
// ============================================================================
`default_nettype none

module smm_block_accum #(
    parameter int DATAWIDTH = 32,
    parameter int NUM_TILES = 4,
    parameter int K_STEPS   = 2,
    localparam int BUSWIDTH = 4 * DATAWIDTH,
    localparam int TW       = $clog2(NUM_TILES),
    localparam int KW       = $clog2(K_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUSWIDTH-1:0] in_data,
    input  logic [TW-1:0]       in_tile,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUSWIDTH-1:0] out_data,
    output logic [TW-1:0]       out_tile,
    output logic                out_last,
    output logic                err
);

    localparam logic [KW-1:0] C_K_FULL    = KW'(K_STEPS);
    localparam logic [TW-1:0] C_LAST_TILE = TW'(NUM_TILES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic [BUSWIDTH-1:0]   acc_q [NUM_TILES];
    logic [BUSWIDTH-1:0]   acc_d [NUM_TILES];
    logic [KW-1:0]         cnt_q [NUM_TILES];
    logic [KW-1:0]         cnt_d [NUM_TILES];
    logic                  w_all_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        w_all_full = 1'b1;

        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    if (cnt_q[in_tile] == C_K_FULL) begin
                        // Extra partial for a complete tile is dropped, flagged sticky.
                        err_d = 1'b1;
                    end else begin
                        if (cnt_q[in_tile] == '0) begin
                            acc_d[in_tile] = in_data;
                        end else begin
                            for (int l = 0; l < 4; l++) begin
                                acc_d[in_tile][l*DATAWIDTH +: DATAWIDTH] =
                                    acc_q[in_tile][l*DATAWIDTH +: DATAWIDTH] +
                                    in_data[l*DATAWIDTH +: DATAWIDTH];
                            end
                        end
                        cnt_d[in_tile] = cnt_q[in_tile] + KW'(1);
                    end

                    for (int i = 0; i < NUM_TILES; i++) begin
                        if (cnt_d[i] != C_K_FULL) begin
                            w_all_full = 1'b0;
                        end
                    end
                    if (w_all_full) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (out_ready) begin
                    if (ptr_q == C_LAST_TILE) begin
                        acc_d   = '{default: '0};
                        cnt_d   = '{default: '0};
                        ptr_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        ptr_d = ptr_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = out_valid ? acc_q[ptr_q] : '0;
    assign out_tile  = ptr_q;
    assign out_last  = out_valid && (ptr_q == C_LAST_TILE);
    assign err       = err_q;

endmodule

`default_nettype wire
